// File: rtl/tdm_pkg.sv
// tdm_pkg: definitions shared by the TDM mux (transmit) and demux (receive)
// ends of the board link, so both sides agree on framing.
//   state_e          receiver framing state (HUNT / RUN)
//   DEF_N_CH, DEF_W  default slot count per frame and lane width
//   slot_w()         width of a slot counter for n slots
package tdm_pkg;

  localparam int DEF_N_CH = 8;
  localparam int DEF_W    = 1;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A one-slot frame still needs a 1-bit counter; $clog2(1) would give 0.
  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter for the TDM demux.
//   clk, resetn  clock, asynchronous active-low reset (counter -> 0)
//   clr_i        return to slot 0 (highest priority)
//   load1_i      jump to slot 1 (slot 0 was just consumed by a sync)
//   inc_i        advance to the next slot
//   slot_o       current slot index
//   last_o       high when slot_o is the final slot of the frame
// The counter never wraps by overflow; the owner clears it on the last slot.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int SLOT_W = slot_w(N_CH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              last_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == SLOT_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the TDM link. Captures N_CH slots of W bits into a
// shadow register and publishes the whole frame at once on dout.
//   clk, resetn  clock, asynchronous active-low reset
//   en           slot strobe; din/sync are valid in any cycle where en=1.
//                There is no back-pressure: every strobed slot is consumed.
//   sync         frame marker, qualified by en, present only in slot 0
//   din          slot data (W bits)
//   dout         published frame, channel k at dout[k*W +: W]
//   frame_vld    one-cycle pulse: dout updated on this edge
//   sync_err     one-cycle pulse: framing violation seen
//   locked       FSM state bit (1 = RUN, 0 = HUNT); doubles as state debug
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic            sync,
  input  logic [W-1:0]    din,
  output logic [N_CH*W-1:0] dout,
  output logic            frame_vld,
  output logic            sync_err,
  output logic            locked
);

  localparam int SLOT_W = slot_w(N_CH);
  // The last slot goes straight to dout, so only N_CH-1 slots need shadowing.
  localparam int SH_W   = (N_CH - 1) * W;

  state_e              state_q, state_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic [N_CH*W-1:0]   dout_q, dout_d;
  logic                frame_vld_q, frame_vld_d;
  logic                sync_err_q, sync_err_d;

  logic                ctr_clr, ctr_load1, ctr_inc;
  logic [SLOT_W-1:0]   slot;
  logic                slot_last;

  tdm_slot_ctr #(
    .N_CH   (N_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_ctr (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (ctr_clr),
    .load1_i (ctr_load1),
    .inc_i   (ctr_inc),
    .slot_o  (slot),
    .last_o  (slot_last)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    dout_d      = dout_q;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;
    ctr_clr     = 1'b0;
    ctr_load1   = 1'b0;
    ctr_inc     = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0 +: W] = din;
            ctr_load1        = 1'b1;
            state_d          = RUN;
          end
        end
        RUN: begin
          if (slot == '0) begin
            if (sync) begin
              shadow_d[0 +: W] = din;
              ctr_load1        = 1'b1;
            end else begin
              // Lost framing: drop lock, capture nothing, wait for a sync.
              sync_err_d = 1'b1;
              ctr_clr    = 1'b1;
              state_d    = HUNT;
            end
          end else if (sync) begin
            // Sync arrived early: abandon the partial frame and treat this
            // slot as slot 0 of a new one. dout is left untouched.
            sync_err_d       = 1'b1;
            shadow_d[0 +: W] = din;
            ctr_load1        = 1'b1;
          end else if (slot_last) begin
            dout_d      = {din, shadow_q};
            frame_vld_d = 1'b1;
            ctr_clr     = 1'b1;
          end else begin
            shadow_d[int'(slot) * W +: W] = din;
            ctr_inc                       = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          ctr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      dout_q      <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign dout      = dout_q;
  assign frame_vld = frame_vld_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: a 4x1 instance driven from a vector table and an
// 8x4 instance driven by a hand-written sequence including a mid-frame reset.
module tb_tdm_demux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---------------- DUT A: N_CH=4, W=1 ----------------
  logic       en_a, sync_a;
  logic [0:0] din_a;
  logic [3:0] dout_a;
  logic       vld_a, err_a, lock_a;

  tdm_demux #(.N_CH(4), .W(1)) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en_a),
    .sync      (sync_a),
    .din       (din_a),
    .dout      (dout_a),
    .frame_vld (vld_a),
    .sync_err  (err_a),
    .locked    (lock_a)
  );

  // ---------------- DUT B: N_CH=8, W=4 ----------------
  logic        en_b, sync_b;
  logic [3:0]  din_b;
  logic [31:0] dout_b;
  logic        vld_b, err_b, lock_b;

  tdm_demux #(.N_CH(8), .W(4)) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en_b),
    .sync      (sync_b),
    .din       (din_b),
    .dout      (dout_b),
    .frame_vld (vld_b),
    .sync_err  (err_b),
    .locked    (lock_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       sync;
    logic       din;
    logic [3:0] exp_dout;
    logic       exp_vld;
    logic       exp_err;
    logic       exp_lock;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic e, input logic s, input logic d,
                     input logic [3:0] xd, input logic xv, input logic xe, input logic xl);
    vec_t v;
    v.en = e; v.sync = s; v.din = d;
    v.exp_dout = xd; v.exp_vld = xv; v.exp_err = xe; v.exp_lock = xl;
    vec_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Drive A, wait for the sampling edge, then look 1 time unit later.
  task automatic drive_a(input logic e, input logic s, input logic d);
    en_a = e; sync_a = s; din_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic e, input logic s, input logic [3:0] d);
    en_b = e; sync_b = s; din_b = d;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    en_a = 0; sync_a = 0; din_a = 0;
    en_b = 0; sync_b = 0; din_b = 0;
    resetn = 1'b0;

    // 1: reset held with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      en_a   = 1'($urandom_range(0, 1));
      sync_a = 1'($urandom_range(0, 1));
      din_a  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("rst%0d dout", i), 32'(dout_a), 32'h0);
      check($sformatf("rst%0d pulses", i), {30'b0, vld_a, err_a}, 32'h0);
      check($sformatf("rst%0d locked", i), 32'(lock_a), 32'h0);
    end
    en_a = 0; sync_a = 0; din_a = 0;
    @(negedge clk);
    resetn = 1'b1;

    // Still hunting after release: a non-sync slot is ignored.
    add(1,0,1, 4'h0,0,0,0);
    // 2: three clean back-to-back frames
    add(1,1,1, 4'h0,0,0,1);
    add(1,0,0, 4'h0,0,0,1);
    add(1,0,1, 4'h0,0,0,1);
    add(1,0,1, 4'hD,1,0,1);
    add(1,1,0, 4'hD,0,0,1);
    add(1,0,1, 4'hD,0,0,1);
    add(1,0,1, 4'hD,0,0,1);
    add(1,0,0, 4'h6,1,0,1);
    add(1,1,1, 4'h6,0,0,1);
    add(1,0,1, 4'h6,0,0,1);
    add(1,0,0, 4'h6,0,0,1);
    add(1,0,0, 4'h3,1,0,1);
    // 3: strobe gaps (idle cycles with sync/din wiggling must be ignored)
    add(0,1,1, 4'h3,0,0,1);
    add(1,1,1, 4'h3,0,0,1);
    add(0,0,0, 4'h3,0,0,1);
    add(0,1,1, 4'h3,0,0,1);
    add(1,0,0, 4'h3,0,0,1);
    add(0,1,1, 4'h3,0,0,1);
    add(0,0,0, 4'h3,0,0,1);
    add(1,0,1, 4'h3,0,0,1);
    add(0,0,1, 4'h3,0,0,1);
    add(0,1,0, 4'h3,0,0,1);
    add(1,0,1, 4'hD,1,0,1);
    add(0,0,0, 4'hD,0,0,1);
    add(0,0,0, 4'hD,0,0,1);
    // 4: early sync at slot 2, then resync frame {1,0,0,1}
    add(1,1,0, 4'hD,0,0,1);
    add(1,0,1, 4'hD,0,0,1);
    add(1,1,1, 4'hD,0,1,1);
    add(1,0,0, 4'hD,0,0,1);
    add(1,0,0, 4'hD,0,0,1);
    add(1,0,1, 4'h9,1,0,1);
    // early sync in the last slot also wins over publishing
    add(1,1,1, 4'h9,0,0,1);
    add(1,0,1, 4'h9,0,0,1);
    add(1,0,1, 4'h9,0,0,1);
    add(1,1,0, 4'h9,0,1,1);
    add(1,0,1, 4'h9,0,0,1);
    add(1,0,1, 4'h9,0,0,1);
    add(1,0,1, 4'hE,1,0,1);
    // 5: missing sync at slot 0 -> HUNT, slots ignored until next sync
    add(1,0,1, 4'hE,0,1,0);
    add(1,0,1, 4'hE,0,0,0);
    add(1,0,0, 4'hE,0,0,0);
    add(0,1,1, 4'hE,0,0,0);
    add(1,1,0, 4'hE,0,0,1);
    add(1,0,0, 4'hE,0,0,1);
    add(1,0,0, 4'hE,0,0,1);
    add(1,0,1, 4'h8,1,0,1);
    add(0,0,0, 4'h8,0,0,1);

    @(posedge clk);
    #1;
    for (int i = 0; i < vec_q.size(); i++) begin
      drive_a(vec_q[i].en, vec_q[i].sync, vec_q[i].din);
      check($sformatf("vec%0d dout", i),   32'(dout_a), 32'(vec_q[i].exp_dout));
      check($sformatf("vec%0d vld", i),    32'(vld_a),  32'(vec_q[i].exp_vld));
      check($sformatf("vec%0d err", i),    32'(err_a),  32'(vec_q[i].exp_err));
      check($sformatf("vec%0d locked", i), 32'(lock_a), 32'(vec_q[i].exp_lock));
    end
    en_a = 0; sync_a = 0; din_a = 0;

    // 6: wide instance, din = slot index
    for (int s = 0; s < 8; s++) begin
      drive_b(1'b1, (s == 0), 4'(s));
      check($sformatf("b_f1 s%0d vld", s), 32'(vld_b), (s == 7) ? 32'h1 : 32'h0);
      check($sformatf("b_f1 s%0d locked", s), 32'(lock_b), 32'h1);
    end
    check("b_f1 dout", dout_b, 32'h7654_3210);
    drive_b(1'b0, 1'b0, 4'h0);
    check("b_f1 vld drop", 32'(vld_b), 32'h0);
    check("b_f1 dout hold", dout_b, 32'h7654_3210);

    // partial frame, then asynchronous reset between clock edges
    for (int s = 0; s < 4; s++) drive_b(1'b1, (s == 0), 4'hA);
    #2;
    resetn = 1'b0;
    #1;
    check("b_rst dout", dout_b, 32'h0);
    check("b_rst locked", 32'(lock_b), 32'h0);
    check("b_rst pulses", {30'b0, vld_b, err_b}, 32'h0);
    en_b = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drive_b(1'b1, 1'b0, 4'h5);
    check("b_hunt locked", 32'(lock_b), 32'h0);
    check("b_hunt dout", dout_b, 32'h0);
    for (int s = 0; s < 8; s++) begin
      drive_b(1'b1, (s == 0), 4'(8 + s));
      check($sformatf("b_f2 s%0d err", s), 32'(err_b), 32'h0);
    end
    check("b_f2 vld", 32'(vld_b), 32'h1);
    check("b_f2 dout", dout_b, 32'hFEDC_BA98);
    drive_b(1'b0, 1'b0, 4'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
